bus_addr_decode: RTL and testbench

Address decoder and access sequencer on the master side of the slave bus. It accepts a master request, decodes the address into one of eight active-low slave chip selects, and holds that select until the slave read mux returns ready. It then reports completion, or an error on a bad address or a timeout. It sits directly upstream of the slave read mux: its `s_csn` outputs drive the slaves' csn inputs and the mux's select inputs, and the mux's `m_rdy` returns here as `rdy`.

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_timeout_cnt.sv | 35 +++
 rtl/bus_addr_decode.sv | 139 +++++++++++++
 tb/tb_bus_addr_decode.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg
// Shared definitions for the master-side address decoder and the slave read
// mux: slave count, chip-select / ready polarities, decoder FSM states and a
// helper that builds a one-hot-low chip-select vector from a slave index.
package bus_pkg;

  localparam int unsigned NUM_SLV = 8;
  localparam int unsigned IDX_W   = $clog2(NUM_SLV);

  localparam logic CSN_ENABLE  = 1'b0;
  localparam logic CSN_DISABLE = 1'b1;
  localparam logic RDY_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    RESP
  } bus_dec_state_t;

  // Chip-select vector with only slave 'idx' enabled.
  function automatic logic [NUM_SLV-1:0] csn_decode(input logic [IDX_W-1:0] idx);
    logic [NUM_SLV-1:0] v;
    v      = {NUM_SLV{CSN_DISABLE}};
    v[idx] = CSN_ENABLE;
    return v;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt
// Access timeout counter. Counts up from 0 while enabled and flags 'expired'
// once it reaches TIMEOUT-1; it then holds there, so it never wraps.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   clear   in  force the count back to 0 (takes priority over enable)
//   enable  in  advance the count by one this cycle
//   expired out count equals TIMEOUT-1
module bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == LAST);

endmodule

// File: rtl/bus_addr_decode.sv
// bus_addr_decode
// Master-side address decoder and access sequencer. A request in IDLE is
// decoded from m_addr[SEL_LSB+2:SEL_LSB]; any set address bit above that
// field is a decode error. A good address drives one active-low chip select
// until the slave mux returns rdy, then a one-cycle done pulse is issued with
// err as qualifier.
// Optional feature: define BUS_TIMEOUT_EN to build the access timeout
// (ACTIVE aborts with err after TIMEOUT cycles). Without it ACTIVE waits for
// rdy indefinitely and TIMEOUT is unused.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   m_req   in  request pulse, sampled only while busy = 0
//   m_addr  in  access address, sampled with m_req
//   rdy     in  ready from the slave read mux, honoured only in ACTIVE
//   s_csn   out one-hot-low slave chip selects
//   busy    out high while not IDLE
//   done    out one-cycle completion pulse
//   err     out error qualifier, valid with done
//
// state  | meaning
// IDLE   | waiting for m_req, no chip select driven
// ACTIVE | chip select held, waiting for rdy (or timeout)
// RESP   | done pulse with err, chip selects released
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned SEL_LSB = 28,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_req,
  input  logic [31:0]        m_addr,
  input  logic               rdy,
  output logic [NUM_SLV-1:0] s_csn,
  output logic               busy,
  output logic               done,
  output logic               err
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("bus_addr_decode: TIMEOUT must be at least 2");
  end

  bus_dec_state_t     r_state;
  logic [NUM_SLV-1:0] r_csn;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  // Shift the index field down to bit 0; whatever remains above it must be 0.
  logic [31:0]        w_addr_sh;
  logic [IDX_W-1:0]   w_idx;
  logic               w_addr_ok;

  assign w_addr_sh = m_addr >> SEL_LSB;
  assign w_idx     = w_addr_sh[IDX_W-1:0];
  assign w_addr_ok = ((w_addr_sh >> IDX_W) == 32'd0);

`ifdef BUS_TIMEOUT_EN
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_expired;

  // Count only in ACTIVE; held at 0 everywhere else so each access starts fresh.
  assign w_cnt_clear = (r_state != ACTIVE);
  assign w_cnt_en    = (r_state == ACTIVE);

  bus_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_cnt_clear),
    .enable (w_cnt_en),
    .expired(w_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_csn   <= {NUM_SLV{CSN_DISABLE}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (m_req) begin
            r_busy <= 1'b1;
            if (w_addr_ok) begin
              r_state <= ACTIVE;
              r_csn   <= csn_decode(w_idx);
            end else begin
              r_state <= RESP;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          // rdy is checked first so a ready on the last allowed cycle still
          // completes cleanly.
          if (rdy) begin
            r_state <= RESP;
            r_csn   <= {NUM_SLV{CSN_DISABLE}};
            r_done  <= 1'b1;
`ifdef BUS_TIMEOUT_EN
          end else if (w_expired) begin
            r_state <= RESP;
            r_csn   <= {NUM_SLV{CSN_DISABLE}};
            r_done  <= 1'b1;
            r_err   <= 1'b1;
`endif
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_csn   <= {NUM_SLV{CSN_DISABLE}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_csn = r_csn;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;

endmodule

// File: tb/tb_bus_addr_decode.sv
module tb_bus_addr_decode;
  import bus_pkg::*;

  localparam int unsigned TB_SEL_LSB = 28;
  localparam int unsigned TB_TIMEOUT = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_req;
  logic [31:0] m_addr;
  logic        rdy;
  logic [7:0]  s_csn;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  bus_addr_decode #(
    .SEL_LSB(TB_SEL_LSB),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .m_req (m_req),
    .m_addr(m_addr),
    .rdy   (rdy),
    .s_csn (s_csn),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: a good address has nothing set above the 3-bit index field.
  function automatic bit addr_good(input logic [31:0] a);
    logic [63:0] wide;
    wide = 64'(a);
    return (wide >> (TB_SEL_LSB + 3)) == 64'd0;
  endfunction

  function automatic logic [7:0] exp_csn(input logic [31:0] a);
    int unsigned idx;
    idx = (a >> TB_SEL_LSB) % NUM_SLV;
    return 8'hFF & ~(8'd1 << idx);
  endfunction

  // One access: rdy rises in ACTIVE cycle d (0 = first select cycle) and
  // stays high; an optional stray m_req is driven in cycle inj.
  task automatic run_access(input logic [31:0] addr, input int d, input int inj,
                            input logic [31:0] inj_addr, input string name);
    bit         good;
    bit         e;
    int         l;
    logic [7:0] cs;
    good = addr_good(addr);
    e    = !good || (TO_EN && d >= int'(TB_TIMEOUT));
    if (!good)                               l = 0;
    else if (TO_EN && d >= int'(TB_TIMEOUT)) l = TB_TIMEOUT;
    else                                     l = d + 1;
    cs = good ? exp_csn(addr) : 8'hFF;

    @(negedge clk);
    m_req  = 1'b1;
    m_addr = addr;
    rdy    = RDY_DISABLE;
    for (int c = 0; c <= l + 1; c++) begin
      @(negedge clk);
      m_req  = 1'b0;
      m_addr = $urandom;
      if (c < l) rdy = (c >= d);
      else       rdy = 1'($urandom);
      if (c == inj && c <= l) begin
        m_req  = 1'b1;
        m_addr = inj_addr;
      end
      if (c < l) begin
        chk({name, ":csn_sel"}, 32'(s_csn), 32'(cs));
        chk({name, ":busy_sel"}, 32'(busy), 32'd1);
        chk({name, ":done_sel"}, 32'(done), 32'd0);
      end else if (c == l) begin
        chk({name, ":csn_resp"}, 32'(s_csn), 32'hFF);
        chk({name, ":done_resp"}, 32'(done), 32'd1);
        chk({name, ":err_resp"}, 32'(err), 32'(e));
        chk({name, ":busy_resp"}, 32'(busy), 32'd1);
      end else begin
        chk({name, ":csn_idle"}, 32'(s_csn), 32'hFF);
        chk({name, ":done_idle"}, 32'(done), 32'd0);
        chk({name, ":busy_idle"}, 32'(busy), 32'd0);
      end
    end
    m_req = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    m_req  = 1'b1;
    m_addr = 32'h1000_0000;
    rdy    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst:csn", 32'(s_csn), 32'hFF);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    rst   = 1'b0;
    m_req = 1'b0;
    rdy   = RDY_DISABLE;

    run_access(32'h3000_0010, 0, -1, 32'h0, "basic");
    run_access(32'h8000_0000, 0, -1, 32'h0, "dec_err");
    run_access(32'h1000_0000, 120, -1, 32'h0, "long_wait");
    run_access(32'h0000_0004, TB_TIMEOUT - 1, -1, 32'h0, "rdy_at_last");
    run_access(32'h2000_0000, TB_TIMEOUT, -1, 32'h0, "timeout");
    run_access(32'h7000_0000, 3, 1, 32'h1000_0000, "ignore_req");
    run_access(32'h5000_0000, 1, 2, 32'h6000_0000, "req_in_resp");

    // Reset in the middle of an access: selects drop, no done follows.
    @(negedge clk);
    m_req  = 1'b1;
    m_addr = 32'h4000_0000;
    rdy    = RDY_DISABLE;
    @(negedge clk);
    m_req = 1'b0;
    chk("midrst:csn_before", 32'(s_csn), 32'hEF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst:csn", 32'(s_csn), 32'hFF);
    chk("midrst:busy", 32'(busy), 32'd0);
    chk("midrst:done", 32'(done), 32'd0);
    rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst:no_done", 32'(done), 32'd0);
      chk("midrst:csn_after", 32'(s_csn), 32'hFF);
    end
    rdy = RDY_DISABLE;

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) a = $urandom | 32'h8000_0000;
      else                           a = $urandom & 32'h7FFF_FFFF;
      run_access(a, int'($urandom_range(0, TB_TIMEOUT + 3)), int'($urandom_range(0, 8)),
                 $urandom, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
